// File: rtl/sdram_test_gen.sv
// SDRAM traffic generator: writes an XOR pattern to a block, reads it back, reports on LED.
// Optional build macro SDRAM_TEST_LOOP_EN: re-run forever with the seed bumped after each pass.
module sdram_test_gen #(
  parameter int unsigned       ADDR_W     = 22,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       TEST_WORDS = 256,
  parameter int unsigned       BASE_ADDR  = 0,
  parameter logic [DATA_W-1:0] SEED       = 16'hA5C3,
  parameter int unsigned       BLINK_DIV  = 25000000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              INIT_DONE,
  output logic              WR_REQ,
  output logic              RD_REQ,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  input  logic              DONE,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              BUSY,
  output logic [15:0]       ERR_CNT,
  output logic              LED
);

  // state     | meaning
  // WAIT_INIT | idle until the controller finishes power-up
  // WR_ISSUE  | present address/data, raise WR_REQ
  // WR_WAIT   | hold the write until DONE
  // RD_ISSUE  | present address, raise RD_REQ
  // RD_WAIT   | hold the read until DONE, compare returned word
  // CHECK     | one-cycle verdict
  // PASS      | LED on (or next loop iteration)
  // FAIL      | LED blinks, terminal
  typedef enum logic [2:0] {
    WAIT_INIT, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, CHECK, PASS, FAIL
  } state_t;

  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(TEST_WORDS - 1);
  localparam logic [31:0]       BLINK_LOAD = 32'(BLINK_DIV - 1);

  state_t              state;
  logic [ADDR_W-1:0]   word_cnt;
  logic [31:0]         blink_cnt;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   pattern;
  logic [DATA_W-1:0]   seed_q;
  logic                last_word;
  logic                mismatch;
  logic                in_test;

`ifndef SDRAM_TEST_LOOP_EN
  assign seed_q = SEED;
`endif

  assign cur_addr  = BASE + word_cnt;
  assign pattern   = DATA_W'(cur_addr) ^ seed_q;
  assign last_word = (word_cnt == LAST_WORD);
  assign mismatch  = (RD_DATA != pattern);
  assign in_test   = (state != WAIT_INIT) && (state != PASS) && (state != FAIL);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= WAIT_INIT;
      WR_REQ    <= 1'b0;
      RD_REQ    <= 1'b0;
      ADDR      <= BASE;
      WR_DATA   <= '0;
      BUSY      <= 1'b1;
      ERR_CNT   <= '0;
      LED       <= 1'b0;
      word_cnt  <= '0;
      blink_cnt <= '0;
`ifdef SDRAM_TEST_LOOP_EN
      seed_q    <= SEED;
`endif
    end else if (in_test && !INIT_DONE) begin
      // controller lost init: abandon the run and start over from word 0
      state    <= WAIT_INIT;
      WR_REQ   <= 1'b0;
      RD_REQ   <= 1'b0;
      word_cnt <= '0;
      ERR_CNT  <= '0;
      BUSY     <= 1'b1;
    end else begin
      case (state)
        WAIT_INIT: begin
          BUSY <= 1'b1;
          if (INIT_DONE) state <= WR_ISSUE;
        end
        WR_ISSUE: begin
          ADDR    <= cur_addr;
          WR_DATA <= pattern;
          WR_REQ  <= 1'b1;
          state   <= WR_WAIT;
        end
        WR_WAIT: begin
          if (DONE) begin
            WR_REQ <= 1'b0;
            if (last_word) begin
              word_cnt <= '0;
              state    <= RD_ISSUE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
              state    <= WR_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          ADDR   <= cur_addr;
          RD_REQ <= 1'b1;
          state  <= RD_WAIT;
        end
        RD_WAIT: begin
          if (DONE) begin
            RD_REQ <= 1'b0;
            if (mismatch && (ERR_CNT != 16'hFFFF)) ERR_CNT <= ERR_CNT + 16'd1;
            if (last_word) begin
              state <= CHECK;
            end else begin
              word_cnt <= word_cnt + 1'b1;
              state    <= RD_ISSUE;
            end
          end
        end
        CHECK: begin
          BUSY <= 1'b0;
          if (ERR_CNT == 16'd0) begin
            state <= PASS;
`ifdef SDRAM_TEST_LOOP_EN
            LED   <= ~LED;
`else
            LED   <= 1'b1;
`endif
          end else begin
            state     <= FAIL;
            LED       <= 1'b0;
            blink_cnt <= BLINK_LOAD;
          end
        end
        PASS: begin
`ifdef SDRAM_TEST_LOOP_EN
          seed_q   <= seed_q + 1'b1;
          word_cnt <= '0;
          BUSY     <= 1'b1;
          state    <= WR_ISSUE;
`else
          LED      <= 1'b1;
`endif
        end
        FAIL: begin
          if (blink_cnt == 32'd0) begin
            LED       <= ~LED;
            blink_cnt <= BLINK_LOAD;
          end else begin
            blink_cnt <= blink_cnt - 32'd1;
          end
        end
        default: state <= WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_test_gen.sv
// Directed bench for sdram_test_gen: ideal memory responder with programmable DONE latency.
module tb_sdram_test_gen;

  logic        clk = 1'b0;
  logic        rst_n, init_done, wr_req, rd_req, done, busy, led;
  logic [21:0] addr;
  logic [15:0] wr_data, rd_data, err_cnt;

  logic        init_w, wr_req_w, rd_req_w, done_w, busy_w, led_w;
  logic [21:0] addr_w;
  logic [15:0] wr_data_w, rd_data_w, err_cnt_w;

  int total = 0;
  int bad   = 0;

  int          done_dly = 3;
  int          bad_addr = -1;
  int          cnt = 0;
  int          n_rd = 0;
  logic        prev_req = 1'b0;
  logic        prev_wr = 1'b0;
  logic [21:0] prev_addr = '0;
  logic [15:0] prev_data = '0;
  logic [15:0] mem   [256];
  logic [15:0] mem_w [256];
  logic [21:0] wa_log[$];
  logic [15:0] wd_log[$];
  logic [21:0] wa_log_w[$];
  logic [15:0] wd_log_w[$];

  always #5 clk = ~clk;

  sdram_test_gen #(.TEST_WORDS(4), .BLINK_DIV(8)) u_dut (
    .CLK(clk), .RSTn(rst_n), .INIT_DONE(init_done), .WR_REQ(wr_req), .RD_REQ(rd_req),
    .ADDR(addr), .WR_DATA(wr_data), .DONE(done), .RD_DATA(rd_data), .BUSY(busy),
    .ERR_CNT(err_cnt), .LED(led)
  );

  sdram_test_gen #(.TEST_WORDS(4), .BLINK_DIV(8), .BASE_ADDR(22'h3FFFFE)) u_dut_wrap (
    .CLK(clk), .RSTn(rst_n), .INIT_DONE(init_w), .WR_REQ(wr_req_w), .RD_REQ(rd_req_w),
    .ADDR(addr_w), .WR_DATA(wr_data_w), .DONE(done_w), .RD_DATA(rd_data_w), .BUSY(busy_w),
    .ERR_CNT(err_cnt_w), .LED(led_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder for the main instance, plus handshake protocol checks.
  always @(negedge clk) begin
    total++;
    assert (!(wr_req && rd_req)) else begin
      bad++;
      $error("FAIL req_overlap: observed wr=%b rd=%b expected one-hot", wr_req, rd_req);
    end
    if ((wr_req || rd_req) && prev_req) begin
      total++;
      assert (addr === prev_addr && wr_data === prev_data && wr_req === prev_wr) else begin
        bad++;
        $error("FAIL req_stable: observed addr=%h data=%h expected addr=%h data=%h",
               addr, wr_data, prev_addr, prev_data);
      end
    end
    prev_req  = wr_req || rd_req;
    prev_wr   = wr_req;
    prev_addr = addr;
    prev_data = wr_data;
    if (done) begin
      done = 1'b0;
      cnt  = 0;
    end else if (wr_req || rd_req) begin
      if (cnt >= done_dly) begin
        done = 1'b1;
        if (wr_req) begin
          mem[addr[7:0]] = wr_data;
          wa_log.push_back(addr);
          wd_log.push_back(wr_data);
        end else begin
          rd_data = (int'(addr) == bad_addr) ? 16'h0000 : mem[addr[7:0]];
          n_rd++;
        end
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (done_w) begin
      done_w = 1'b0;
    end else if (wr_req_w || rd_req_w) begin
      done_w = 1'b1;
      if (wr_req_w) begin
        mem_w[addr_w[7:0]] = wr_data_w;
        wa_log_w.push_back(addr_w);
        wd_log_w.push_back(wr_data_w);
      end else begin
        rd_data_w = mem_w[addr_w[7:0]];
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wa_log.delete();
    wd_log.delete();
    n_rd = 0;
  endtask

  task automatic wait_busy_low(input string tag, input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  logic [15:0] exp_wd   [4] = '{16'hA5C3, 16'hA5C2, 16'hA5C1, 16'hA5C0};
  logic [21:0] exp_wa_w [4] = '{22'h3FFFFE, 22'h3FFFFF, 22'h000000, 22'h000001};
  logic [15:0] exp_wd_w [4] = '{16'h5A3D, 16'h5A3C, 16'hA5C3, 16'hA5C2};
  int          dly_set  [2] = '{0, 50};

  initial begin
    rst_n = 1'b0; init_done = 1'b0; init_w = 1'b0;
    done = 1'b0; rd_data = '0; done_w = 1'b0; rd_data_w = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err", err_cnt, 0);
    chk("rst_led", led, 0);
    chk("rst_wrap_addr", addr_w, 22'h3FFFFE);
    rst_n = 1'b1;

    repeat (100) begin
      @(negedge clk);
      chk("idle_no_req", {wr_req, rd_req}, 0);
    end
    chk("idle_busy", busy, 1);
    chk("idle_led", led, 0);

    init_done = 1'b1;
    repeat (2) @(negedge clk);
    chk("first_wr_req", wr_req, 1);
    chk("first_addr", addr, 0);
    chk("first_wr_data", wr_data, 16'hA5C3);
    wait_busy_low("pass_timeout", 500);
    chk("pass_err", err_cnt, 0);
    chk("pass_led", led, 1);
    chk("pass_n_rd", n_rd, 4);
    chk("pass_n_wr", wa_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("pass_wr_addr", wa_log[i], i);
      chk("pass_wr_data", wd_log[i], exp_wd[i]);
    end
    repeat (20) @(negedge clk);
    chk("pass_led_steady", led, 1);
    chk("pass_busy_steady", busy, 0);

    bad_addr = 2;
    do_reset();
    wait_busy_low("fail_timeout", 500);
    chk("fail_err", err_cnt, 1);
    chk("fail_led_k0", led, 0);
    repeat (7) @(negedge clk);
    chk("fail_led_k7", led, 0);
    @(negedge clk);
    chk("fail_led_k8", led, 1);
    repeat (7) @(negedge clk);
    chk("fail_led_k15", led, 1);
    @(negedge clk);
    chk("fail_led_k16", led, 0);

    bad_addr = -1;
    for (int d = 0; d < 2; d++) begin
      done_dly = dly_set[d];
      do_reset();
      wait_busy_low("dly_timeout", 2000);
      chk("dly_err", err_cnt, 0);
      chk("dly_led", led, 1);
      chk("dly_n_rd", n_rd, 4);
      chk("dly_n_wr", wa_log.size(), 4);
    end

    done_dly = 3;
    bad_addr = 1;
    do_reset();
    begin
      int n = 0;
      while (!(rd_req === 1'b1 && addr === 22'd2) && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("abort_third_read_seen", {rd_req, addr}, {1'b1, 22'd2});
    end
    chk("abort_err_before", err_cnt, 1);
    init_done = 1'b0;
    @(negedge clk);
    chk("abort_rd_req", rd_req, 0);
    chk("abort_err", err_cnt, 0);
    chk("abort_busy", busy, 1);
    repeat (5) @(negedge clk);
    chk("abort_no_req", {wr_req, rd_req}, 0);
    bad_addr = -1;
    wa_log.delete();
    wd_log.delete();
    init_done = 1'b1;
    repeat (2) @(negedge clk);
    chk("restart_wr_req", wr_req, 1);
    chk("restart_addr", addr, 0);
    chk("restart_wr_data", wr_data, 16'hA5C3);
    wait_busy_low("restart_timeout", 500);
    chk("restart_err", err_cnt, 0);
    chk("restart_led", led, 1);

    init_w = 1'b1;
    begin
      int n = 0;
      while (busy_w !== 1'b0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("wrap_timeout", busy_w, 0);
    end
    chk("wrap_n_wr", wa_log_w.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_wr_addr", wa_log_w[i], exp_wa_w[i]);
      chk("wrap_wr_data", wd_log_w[i], exp_wd_w[i]);
    end
    chk("wrap_err", err_cnt_w, 0);
    chk("wrap_led", led_w, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
